// File: rtl/reg_bank8.sv
// reg_bank8: eight-entry register bank with registered select for a downstream 8:1 mux.
// Optional build macro REG_BANK_ZERO_REG_EN hard-wires entry 0 to zero and keeps valid[0] set.
module reg_bank8 #(
  parameter int k = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [k-1:0] wdata,
  input  logic         clr,
  input  logic         re,
  input  logic [2:0]   raddr,
  output logic [k-1:0] q0,
  output logic [k-1:0] q1,
  output logic [k-1:0] q2,
  output logic [k-1:0] q3,
  output logic [k-1:0] q4,
  output logic [k-1:0] q5,
  output logic [k-1:0] q6,
  output logic [k-1:0] q7,
  output logic [2:0]   sel,
  output logic         sel_vld,
  output logic [7:0]   valid,
  output logic         rd_uninit
);
`ifdef REG_BANK_ZERO_REG_EN
  localparam bit zr = 1'b1;
`else
  localparam bit zr = 1'b0;
`endif
  localparam logic [7:0] vrst = zr ? 8'h01 : 8'h00;
  logic [7:0][k-1:0] mem;
  logic wok;
  assign wok = we & ~(zr & (waddr == 3'd0));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '0;
      valid     <= vrst;
      sel       <= '0;
      sel_vld   <= 1'b0;
      rd_uninit <= 1'b0;
    end else begin
      if (clr) begin
        mem   <= '0;
        valid <= vrst;
      end else if (wok) begin
        mem[waddr]   <= wdata;
        valid[waddr] <= 1'b1;
      end
      if (re) sel <= raddr;
      sel_vld   <= re;
      // flag uses the mask as it stood before this edge
      rd_uninit <= re & ~valid[raddr];
    end
  end
  assign q0 = zr ? '0 : mem[0];
  assign q1 = mem[1];
  assign q2 = mem[2];
  assign q3 = mem[3];
  assign q4 = mem[4];
  assign q5 = mem[5];
  assign q6 = mem[6];
  assign q7 = mem[7];
endmodule

// File: tb/tb_reg_bank8.sv
// tb_reg_bank8: scoreboard bench for reg_bank8; honours REG_BANK_ZERO_REG_EN when defined.
module tb_reg_bank8;
`ifdef REG_BANK_ZERO_REG_EN
  localparam bit zr = 1'b1;
`else
  localparam bit zr = 1'b0;
`endif
  localparam logic [7:0] vr = zr ? 8'h01 : 8'h00;
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, clr = 1'b0, re = 1'b0;
  logic [2:0] waddr = '0, raddr = '0, sel;
  logic [7:0] wdata = '0, valid;
  logic [7:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic sel_vld, rd_uninit;
  logic [63:0] qall;
  int npass = 0, ntot = 0;
  typedef struct packed {
    logic [63:0] q;
    logic [2:0]  sel;
    logic        sv;
    logic [7:0]  v;
    logic        ru;
  } exp_t;
  exp_t sbq[$];
  logic [7:0][7:0] mm;
  logic [7:0] mv;
  logic [2:0] ms;
  logic msv, mru;

  reg_bank8 #(.k(8)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .re(re), .raddr(raddr), .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .q5(q5), .q6(q6), .q7(q7), .sel(sel), .sel_vld(sel_vld), .valid(valid),
    .rd_uninit(rd_uninit)
  );
  assign qall = {q7, q6, q5, q4, q3, q2, q1, q0};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    ntot++;
    if (obs === exp_v) npass++;
    else $display("FAIL %s got %h want %h", tag, obs, exp_v);
  endtask

  task automatic mreset();
    mm = '0; mv = vr; ms = '0; msv = 1'b0; mru = 1'b0;
  endtask

  task automatic step(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic c, input logic r, input logic [2:0] ra);
    exp_t e;
    we = w; waddr = wa; wdata = wd; clr = c; re = r; raddr = ra;
    mru = r & ~mv[ra];
    msv = r;
    if (r) ms = ra;
    if (c) begin
      mm = '0; mv = vr;
    end else if (w && !(zr && wa == 3'd0)) begin
      mm[wa] = wd; mv[wa] = 1'b1;
    end
    sbq.push_back('{q: mm, sel: ms, sv: msv, v: mv, ru: mru});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("q", qall, e.q);
    chk("sel", {61'd0, sel}, {61'd0, e.sel});
    chk("sel_vld", {63'd0, sel_vld}, {63'd0, e.sv});
    chk("valid", {56'd0, valid}, {56'd0, e.v});
    chk("rd_uninit", {63'd0, rd_uninit}, {63'd0, e.ru});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mreset();
    #12;
    chk("rst_q", qall, 64'd0);
    chk("rst_sel", {61'd0, sel}, 64'd0);
    chk("rst_sel_vld", {63'd0, sel_vld}, 64'd0);
    chk("rst_valid", {56'd0, valid}, {56'd0, vr});
    chk("rst_ru", {63'd0, rd_uninit}, 64'd0);
    rst = 1'b0;
    step(1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 3'd3);
    chk("wr3_q3", {56'd0, q3}, 64'hA5);
    chk("wr3_valid", {56'd0, valid}, zr ? 64'h09 : 64'h08);
    chk("wr3_ru", {63'd0, rd_uninit}, 64'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'h10 + 8'(i), 1'b0, 1'b0, 3'd0);
    chk("fill_valid", {56'd0, valid}, 64'hFF);
    chk("fill_q0", {56'd0, q0}, zr ? 64'h0 : 64'h10);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'(i));
      chk("seq_sel", {61'd0, sel}, 64'(i));
      chk("seq_sv", {63'd0, sel_vld}, 64'd1);
      chk("seq_ru", {63'd0, rd_uninit}, 64'd0);
    end
    step(1'b1, 3'd5, 8'h3C, 1'b1, 1'b0, 3'd0);
    chk("clr_q", qall, 64'd0);
    chk("clr_valid", {56'd0, valid}, {56'd0, vr});
    chk("clr_sel", {61'd0, sel}, 64'd7);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd6);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd1);
      chk("hold_sel", {61'd0, sel}, 64'd6);
      chk("hold_sv", {63'd0, sel_vld}, 64'd0);
    end
    step(1'b1, 3'd0, 8'hAA, 1'b0, 1'b1, 3'd0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0);
    chk("e0_ru", {63'd0, rd_uninit}, 64'd0);
    step(1'b1, 3'd4, 8'h5A, 1'b0, 1'b0, 3'd0);
    we = 1'b1; waddr = 3'd2; wdata = 8'h77; re = 1'b1; raddr = 3'd2;
    #2 rst = 1'b1;
    #1;
    chk("arst_q", qall, 64'd0);
    chk("arst_sel", {61'd0, sel}, 64'd0);
    chk("arst_sv", {63'd0, sel_vld}, 64'd0);
    chk("arst_valid", {56'd0, valid}, {56'd0, vr});
    chk("arst_ru", {63'd0, rd_uninit}, 64'd0);
    rst = 1'b0;
    mreset();
    step(1'b1, 3'd2, 8'h77, 1'b0, 1'b1, 3'd2);
    chk("post_q2", {56'd0, q2}, 64'h77);
    chk("post_sel", {61'd0, sel}, 64'd2);
    chk("post_ru", {63'd0, rd_uninit}, 64'd1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
